// File: rtl/issue_pkg.sv
// Shared opcode constants, writeback slot type, scheduler states and decode
// helpers for the dual-issue scoreboard.
package issue_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } wb_slot_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        logic r;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: r = 1'b0;
            default:                  r = 1'b1;
        endcase
        return r;
    endfunction

    // Unknown opcodes fall into the default arm and behave like R-type.
    function automatic logic uses_rs2(input logic [6:0] op);
        logic r;
        case (op)
            OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: r = 1'b0;
            default:                                            r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        logic r;
        case (op)
            OP_STORE, OP_BRANCH: r = 1'b0;
            default:             r = (rd != 5'd0);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dual_issue_scoreboard_chk.sv
// Property checker for the scoreboard; the set/clear exclusivity property only
// holds when SCOREBOARD_BYPASS_EN is undefined.
module dual_issue_scoreboard_chk #(
    parameter int NREGS = 32
) (
    input logic             clk,
    input logic             n_rst,
    input logic             issue0,
    input logic             issue1,
    input logic [NREGS-1:0] set_mask,
    input logic [NREGS-1:0] clr_mask,
    input logic [NREGS-1:0] busy_vec
);

    a_in_order: assert property (@(posedge clk) disable iff (!n_rst) issue1 |-> issue0);

    a_x0_idle: assert property (@(posedge clk) disable iff (!n_rst) busy_vec[0] == 1'b0);

`ifndef SCOREBOARD_BYPASS_EN
    a_no_set_clr: assert property (@(posedge clk) disable iff (!n_rst)
        (set_mask & clr_mask) == {NREGS{1'b0}});
`endif

endmodule

// File: rtl/wb_delay_line.sv
// Fixed-latency writeback pipe: LAT stages, each carrying one {valid, rd}
// slot per datapath, plus an indication that no stage holds a valid write.
module wb_delay_line
    import issue_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic     clk,
    input  logic     n_rst,
    input  wb_slot_t in0,
    input  wb_slot_t in1,
    output wb_slot_t out0,
    output wb_slot_t out1,
    output logic     empty
);

    wb_slot_t line0_r [LAT];
    wb_slot_t line1_r [LAT];
    logic     empty_s;

    // Shift both slot columns one stage per cycle; reset discards in-flight writes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < LAT; i++) begin
                line0_r[i] <= {1'b0, 5'd0};
                line1_r[i] <= {1'b0, 5'd0};
            end
        end else begin
            line0_r[0] <= in0;
            line1_r[0] <= in1;
            for (int i = 1; i < LAT; i++) begin
                line0_r[i] <= line0_r[i-1];
                line1_r[i] <= line1_r[i-1];
            end
        end
    end

    // Empty when no stage carries a valid write.
    always_comb begin
        empty_s = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            empty_s = empty_s & ~line0_r[i].valid & ~line1_r[i].valid;
        end
    end

    assign out0  = line0_r[LAT-1];
    assign out1  = line1_r[LAT-1];
    assign empty = empty_s;

endmodule

// File: rtl/dual_issue_scoreboard.sv
// In-order dual-issue scoreboard with flush/drain control.
// Define SCOREBOARD_BYPASS_EN to let a consumer issue in its producer's writeback cycle.
module dual_issue_scoreboard
    import issue_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             ins0_valid,
    input  logic [31:0]      ins0,
    input  logic             ins1_valid,
    input  logic [31:0]      ins1,
    input  logic             flush,
    output logic             issue0,
    output logic             issue1,
    output logic             freeze1,
    output logic             freeze2,
    output logic             wb_en1,
    output logic             wb_en2,
    output logic [4:0]       wb_rd1,
    output logic [4:0]       wb_rd2,
    output logic [NREGS-1:0] busy_vec,
    output logic             idle
);

    logic             valid0_s, valid1_s;
    logic [4:0]       d0_rd_s, d0_rs1_s, d0_rs2_s;
    logic [4:0]       d1_rd_s, d1_rs1_s, d1_rs2_s;
    logic             d0_u1_s, d0_u2_s, d0_w_s;
    logic             d1_u1_s, d1_u2_s, d1_w_s;
    logic             haz0_s, haz1_s, pair_conf_s, can_issue_s;
    logic             issue0_s, issue1_s;
    logic [NREGS-1:0] busy_r, hz_busy_s, set_mask_s, clr_mask_s;
    sched_state_t     state_r, state_nxt_s;
    wb_slot_t         wb_in0_s, wb_in1_s, wb_out0_s, wb_out1_s;
    logic             line_empty_s;
    logic             unused_ins_s;

    // An all-zero word is a queue bubble, never a real instruction.
    assign valid0_s = ins0_valid && (ins0 != 32'd0);
    assign valid1_s = ins1_valid && (ins1 != 32'd0);

    assign d0_rd_s  = ins0[11:7];
    assign d0_rs1_s = ins0[19:15];
    assign d0_rs2_s = ins0[24:20];
    assign d0_u1_s  = uses_rs1(ins0[6:0]);
    assign d0_u2_s  = uses_rs2(ins0[6:0]);
    assign d0_w_s   = writes_rd(ins0[6:0], ins0[11:7]);

    assign d1_rd_s  = ins1[11:7];
    assign d1_rs1_s = ins1[19:15];
    assign d1_rs2_s = ins1[24:20];
    assign d1_u1_s  = uses_rs1(ins1[6:0]);
    assign d1_u2_s  = uses_rs2(ins1[6:0]);
    assign d1_w_s   = writes_rd(ins1[6:0], ins1[11:7]);

    assign unused_ins_s = ^{ins0[31:25], ins0[14:12], ins1[31:25], ins1[14:12]};

`ifdef SCOREBOARD_BYPASS_EN
    assign hz_busy_s = busy_r & ~clr_mask_s;
`else
    assign hz_busy_s = busy_r;
`endif

    assign haz0_s = (d0_u1_s && (d0_rs1_s != 5'd0) && hz_busy_s[d0_rs1_s]) ||
                    (d0_u2_s && (d0_rs2_s != 5'd0) && hz_busy_s[d0_rs2_s]) ||
                    (d0_w_s  && hz_busy_s[d0_rd_s]);
    assign haz1_s = (d1_u1_s && (d1_rs1_s != 5'd0) && hz_busy_s[d1_rs1_s]) ||
                    (d1_u2_s && (d1_rs2_s != 5'd0) && hz_busy_s[d1_rs2_s]) ||
                    (d1_w_s  && hz_busy_s[d1_rd_s]);

    // Slot 1 may not read or rewrite what slot 0 is about to write.
    assign pair_conf_s = d0_w_s && ((d1_u1_s && (d1_rs1_s == d0_rd_s)) ||
                                    (d1_u2_s && (d1_rs2_s == d0_rd_s)) ||
                                    (d1_w_s  && (d1_rd_s  == d0_rd_s)));

    assign can_issue_s = n_rst && (state_r == RUN) && !flush;
    assign issue0_s    = can_issue_s && valid0_s && !haz0_s;
    assign issue1_s    = issue0_s && valid1_s && !haz1_s && !pair_conf_s;

    assign wb_in0_s = {issue0_s && d0_w_s, (issue0_s && d0_w_s) ? d0_rd_s : 5'd0};
    assign wb_in1_s = {issue1_s && d1_w_s, (issue1_s && d1_w_s) ? d1_rd_s : 5'd0};

    wb_delay_line #(.LAT(LAT)) u_wb_line (
        .clk   (clk),
        .n_rst (n_rst),
        .in0   (wb_in0_s),
        .in1   (wb_in1_s),
        .out0  (wb_out0_s),
        .out1  (wb_out1_s),
        .empty (line_empty_s)
    );

    // Per-register set (issuing writes) and clear (retiring writes) masks.
    always_comb begin
        set_mask_s = {NREGS{1'b0}};
        clr_mask_s = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            set_mask_s[i] = (wb_in0_s.valid && (wb_in0_s.rd == 5'(i))) ||
                            (wb_in1_s.valid && (wb_in1_s.rd == 5'(i)));
            clr_mask_s[i] = (wb_out0_s.valid && (wb_out0_s.rd == 5'(i))) ||
                            (wb_out1_s.valid && (wb_out1_s.rd == 5'(i)));
        end
    end

    // Scoreboard update; a coincident set overrides the clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Next-state logic: flush enters DRAIN, an empty pipeline returns to RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (flush) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_nxt_s = DRAIN;
                end else if (!(|busy_r) && line_empty_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign issue0   = issue0_s;
    assign issue1   = issue1_s;
    assign freeze1  = n_rst && valid0_s && !issue0_s;
    assign freeze2  = n_rst && valid1_s && !issue1_s;
    assign wb_en1   = wb_out0_s.valid;
    assign wb_en2   = wb_out1_s.valid;
    assign wb_rd1   = wb_out0_s.rd;
    assign wb_rd2   = wb_out1_s.rd;
    assign busy_vec = busy_r;
    assign idle     = (state_r == RUN) && !(|busy_r) && line_empty_s;

    dual_issue_scoreboard_chk #(.NREGS(NREGS)) u_chk (
        .clk      (clk),
        .n_rst    (n_rst),
        .issue0   (issue0_s),
        .issue1   (issue1_s),
        .set_mask (set_mask_s),
        .clr_mask (clr_mask_s),
        .busy_vec (busy_r)
    );

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic checked every
// cycle against a cycle-stamped reference model of register readiness.
module tb_dual_issue_scoreboard;

    localparam int LAT   = 2;
    localparam int NREGS = 32;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADDI_X3 = 32'h00700193;
    localparam logic [31:0] ADDI_X5 = 32'h00500293;
    localparam logic [31:0] ADD_X2  = 32'h00108133;
    localparam logic [31:0] SW_X1   = 32'h00102023;

    logic             clk;
    logic             n_rst;
    logic             ins0_valid, ins1_valid, flush;
    logic [31:0]      ins0, ins1;
    logic             issue0, issue1, freeze1, freeze2;
    logic             wb_en1, wb_en2, idle;
    logic [4:0]       wb_rd1, wb_rd2;
    logic [NREGS-1:0] busy_vec;

    dual_issue_scoreboard #(.LAT(LAT), .NREGS(NREGS)) dut (
        .clk(clk), .n_rst(n_rst),
        .ins0_valid(ins0_valid), .ins0(ins0),
        .ins1_valid(ins1_valid), .ins1(ins1),
        .flush(flush),
        .issue0(issue0), .issue1(issue1),
        .freeze1(freeze1), .freeze2(freeze2),
        .wb_en1(wb_en1), .wb_en2(wb_en2),
        .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
        .busy_vec(busy_vec), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: wb_cyc[r] is the cycle in which r's pending write lands.
    int cyc;
    int wb_cyc [32];
    int pend1 [int];
    int pend2 [int];
    bit draining;
    bit last_issue0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) wb_cyc[r] = -1;
        pend1.delete();
        pend2.delete();
        draining = 1'b0;
    endtask

    function automatic void dec(input logic [31:0] ins, output bit u1, output bit u2,
                                output bit w, output int rd, output int rs1, output int rs2);
        logic [6:0] op;
        op  = ins[6:0];
        rd  = int'(ins[11:7]);
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        u1  = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2  = !(op inside {7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
        w   = !(op inside {7'b0100011, 7'b1100011}) && (rd != 0);
    endfunction

    function automatic bit hz(input int r);
        if (r == 0) return 1'b0;
        return BYP ? (wb_cyc[r] > cyc) : (wb_cyc[r] >= cyc);
    endfunction

    // One clock cycle: check every output mid-cycle, then advance the model.
    task automatic step();
        bit v0, v1, u10, u20, w0, u11, u21, w1, conf, e0, e1, pending;
        int rd0, rs10, rs20, rd1, rs11, rs21;
        logic [31:0] eb;
        @(negedge clk);
        if (!n_rst) model_reset();
        v0 = ins0_valid && (ins0 != 32'd0);
        v1 = ins1_valid && (ins1 != 32'd0);
        dec(ins0, u10, u20, w0, rd0, rs10, rs20);
        dec(ins1, u11, u21, w1, rd1, rs11, rs21);
        conf = w0 && ((u11 && rs11 == rd0) || (u21 && rs21 == rd0) || (w1 && rd1 == rd0));
        e0 = n_rst && !draining && !flush && v0 &&
             !((u10 && hz(rs10)) || (u20 && hz(rs20)) || (w0 && hz(rd0)));
        e1 = e0 && v1 && !conf &&
             !((u11 && hz(rs11)) || (u21 && hz(rs21)) || (w1 && hz(rd1)));
        eb = 32'd0;
        pending = 1'b0;
        for (int r = 1; r < 32; r++) begin
            if (wb_cyc[r] >= cyc) begin
                eb[r] = 1'b1;
                pending = 1'b1;
            end
        end
        chk("issue0", 32'(issue0), 32'(e0));
        chk("issue1", 32'(issue1), 32'(e1));
        chk("freeze1", 32'(freeze1), 32'(n_rst && v0 && !e0));
        chk("freeze2", 32'(freeze2), 32'(n_rst && v1 && !e1));
        chk("wb_en1", 32'(wb_en1), 32'(pend1.exists(cyc)));
        chk("wb_en2", 32'(wb_en2), 32'(pend2.exists(cyc)));
        chk("wb_rd1", 32'(wb_rd1), pend1.exists(cyc) ? 32'(pend1[cyc]) : 32'd0);
        chk("wb_rd2", 32'(wb_rd2), pend2.exists(cyc) ? 32'(pend2[cyc]) : 32'd0);
        chk("busy_vec", busy_vec, eb);
        chk("idle", 32'(idle), 32'(!draining && !pending));
        last_issue0 = issue0;
        if (e0 && w0) begin
            wb_cyc[rd0] = cyc + LAT;
            pend1[cyc + LAT] = rd0;
        end
        if (e1 && w1) begin
            wb_cyc[rd1] = cyc + LAT;
            pend2[cyc + LAT] = rd1;
        end
        if (!n_rst) draining = 1'b0;
        else if (flush) draining = 1'b1;
        else if (draining && !pending) draining = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        ins0_valid = 1'b0; ins0 = 32'd0;
        ins1_valid = 1'b0; ins1 = 32'd0;
        flush = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] x;
        logic [6:0]  op;
        case ($urandom_range(0, 9))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b0110111;
            6: op = 7'b0010111;
            7: op = 7'b1101111;
            8: op = 7'b1100111;
            default: op = 7'b1111111;
        endcase
        x = $urandom;
        x[6:0]   = op;
        x[11:7]  = 5'($urandom_range(0, 4));
        x[19:15] = 5'($urandom_range(0, 4));
        x[24:20] = 5'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) x = 32'd0;
        return x;
    endfunction

    initial begin
        int n;
        cyc = 0;
        last_issue0 = 1'b0;
        model_reset();
        n_rst = 1'b0;
        quiet(2);
        n_rst = 1'b1;
        quiet(1);

        // Independent pair issues together and retires LAT cycles later.
        ins0_valid = 1'b1; ins0 = ADDI_X1;
        ins1_valid = 1'b1; ins1 = ADDI_X3;
        step();
        chk("tp1_busy_c1", busy_vec, 32'h0000000A);
        quiet(1);
        chk("tp1_busy_c2", busy_vec, 32'h0000000A);
        chk("tp1_wb_en1", 32'(wb_en1), 32'd1);
        chk("tp1_wb_en2", 32'(wb_en2), 32'd1);
        chk("tp1_wb_rd1", 32'(wb_rd1), 32'd1);
        chk("tp1_wb_rd2", 32'(wb_rd2), 32'd3);
        quiet(1);
        chk("tp1_busy_c3", busy_vec, 32'd0);
        quiet(2);

        // RAW on x1 inside the pair, then the add waits in slot 0.
        ins0_valid = 1'b1; ins0 = ADDI_X1;
        ins1_valid = 1'b1; ins1 = ADD_X2;
        step();
        ins0 = ADD_X2; ins1_valid = 1'b0; ins1 = 32'd0;
        n = 0;
        do begin n++; step(); end while (!last_issue0 && n < 8);
        chk("tp2_issue_cycle", n, BYP ? 32'd2 : 32'd3);
        quiet(LAT + 2);

        // Store stalls on x1, then travels the line without a write.
        ins0_valid = 1'b1; ins0 = ADDI_X1;
        step();
        ins0 = SW_X1;
        n = 0;
        do begin n++; step(); end while (!last_issue0 && n < 8);
        chk("tp3_issue_cycle", n, BYP ? 32'd2 : 32'd3);
        quiet(LAT - 1);
        chk("tp3_no_wb", 32'(wb_en1), 32'd0);
        quiet(2);

        // Bubble in slot 0 blocks a valid slot 1.
        ins0_valid = 1'b1; ins0 = 32'd0;
        ins1_valid = 1'b1; ins1 = ADDI_X1;
        #1;
        chk("tp4_issue0", 32'(issue0), 32'd0);
        chk("tp4_freeze1", 32'(freeze1), 32'd0);
        chk("tp4_freeze2", 32'(freeze2), 32'd1);
        step();
        quiet(1);

        // Flush with two writes in flight: drain, then resume.
        ins0_valid = 1'b1; ins0 = ADDI_X1;
        ins1_valid = 1'b1; ins1 = ADDI_X3;
        step();
        flush = 1'b1; ins0 = ADDI_X5; ins1_valid = 1'b0; ins1 = 32'd0;
        n = 1;
        step();
        flush = 1'b0;
        do begin n++; step(); end while (!last_issue0 && n < 12);
        chk("tp5_resume_cycle", n, LAT + 2);
        quiet(LAT + 2);

        // Reset right after an issue discards the pending write.
        ins0_valid = 1'b1; ins0 = ADDI_X1;
        step();
        ins0_valid = 1'b0; ins0 = 32'd0;
        n_rst = 1'b0;
        #1;
        chk("tp6_busy", busy_vec, 32'd0);
        chk("tp6_idle", 32'(idle), 32'd1);
        step();
        n_rst = 1'b1;
        quiet(LAT + 2);

        // Random traffic; stalled pairs are sometimes held like a real queue.
        for (int k = 0; k < 3000; k++) begin
            if (!(ins0_valid && !last_issue0 && $urandom_range(0, 1) == 1)) begin
                ins0_valid = ($urandom_range(0, 4) != 0);
                ins0       = rand_ins();
                ins1_valid = ($urandom_range(0, 4) != 0);
                ins1       = rand_ins();
            end
            flush = ($urandom_range(0, 19) == 0);
            n_rst = ($urandom_range(0, 299) != 0);
            step();
        end
        n_rst = 1'b1;
        quiet(LAT + 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
